// File: rtl/gray_capture_pkg.sv
// gray_capture_pkg: shared state type, default widths and latched per-frame configuration
package gray_capture_pkg;
  localparam int DEF_COORD_W = 12;
  localparam int DEF_FCNT_W = 16;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  typedef struct packed {
    logic continuous;
    logic [DEF_COORD_W-1:0] width;
    logic [DEF_COORD_W-1:0] height;
    logic [DEF_COORD_W-1:0] roi_x0;
    logic [DEF_COORD_W-1:0] roi_x1;
    logic [DEF_COORD_W-1:0] roi_y0;
    logic [DEF_COORD_W-1:0] roi_y1;
  } cfg_t;
endpackage

// File: rtl/gray_capture_sequencer_pixel_xy_counter.sv
// pixel_xy_counter: raster x/y position of the pixel being accepted this cycle
// Ports: load_zero makes this cycle's pixel (0,0); en accepts the pixel at the held
// position; cur_x/cur_y/last describe this cycle's pixel; the register advances past it.
module pixel_xy_counter #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_zero,
  input  logic         en,
  input  logic [W-1:0] width,
  input  logic [W-1:0] height,
  output logic [W-1:0] cur_x,
  output logic [W-1:0] cur_y,
  output logic         last
);
  logic [W-1:0] x, y;
  logic x_end, y_end;
  assign cur_x = load_zero ? '0 : x;
  assign cur_y = load_zero ? '0 : y;
  assign x_end = cur_x == width - 1'b1;
  assign y_end = cur_y == height - 1'b1;
  assign last = x_end & y_end;
  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load_zero | en) begin
      x <= x_end ? '0 : cur_x + 1'b1;
      y <= x_end ? (y_end ? '0 : cur_y + 1'b1) : cur_y;
    end
  end
endmodule

// File: rtl/gray_capture_sequencer.sv
// gray_capture_sequencer: arms on command, aligns to frame start, gates pixels and flags the ROI
// Ports: cmd_start/cmd_stop control; cfg_* latched on each frame start; in_frame_start/in_valid
// from the sensor; out_* registered pixel strobe, coordinates, ROI flag and done pulse;
// busy/error/frame_count status.
module gray_capture_sequencer
  import gray_capture_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int FCNT_W = DEF_FCNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               cfg_continuous,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic [COORD_W-1:0] cfg_roi_x0,
  input  logic [COORD_W-1:0] cfg_roi_x1,
  input  logic [COORD_W-1:0] cfg_roi_y0,
  input  logic [COORD_W-1:0] cfg_roi_y1,
  input  logic               in_frame_start,
  input  logic               in_valid,
  output logic               out_valid,
  output logic               out_visual,
  output logic               out_done,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               busy,
  output logic               error,
  output logic [FCNT_W-1:0]  frame_count
);
  state_t state, state_n;
  cfg_t cfg_q, cfg_eff;
  logic stop_pending, fs, start, emit, step, set_err, clr_err, arm_ok, done, last, roi_hit;
  logic [COORD_W-1:0] cur_x, cur_y;
  assign fs = in_frame_start & in_valid;
  assign start = fs & ((state == ARMED & ~cmd_stop) | state == CAPTURE);
  assign emit = start | (state == CAPTURE & in_valid);
  assign step = state == CAPTURE & in_valid & ~fs;
  assign set_err = fs & state == CAPTURE;
  assign arm_ok = cmd_start & ~cmd_stop & |cfg_width & |cfg_height;
  assign clr_err = state == IDLE & arm_ok;
  assign done = state == DONE;
  // the frame-start pixel already uses the configuration being latched this cycle
  assign cfg_eff = start ? {cfg_continuous, cfg_width, cfg_height, cfg_roi_x0, cfg_roi_x1, cfg_roi_y0, cfg_roi_y1} : cfg_q;
  assign roi_hit = cur_x >= cfg_eff.roi_x0 & cur_x <= cfg_eff.roi_x1 & cur_y >= cfg_eff.roi_y0 & cur_y <= cfg_eff.roi_y1;
  pixel_xy_counter #(.W(COORD_W)) u_xy (
    .clock(clock),
    .reset(reset),
    .load_zero(start),
    .en(step),
    .width(cfg_eff.width),
    .height(cfg_eff.height),
    .cur_x(cur_x),
    .cur_y(cur_y),
    .last(last)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = arm_ok ? ARMED : IDLE;
      ARMED: state_n = cmd_stop ? IDLE : start ? (last ? DONE : CAPTURE) : ARMED;
      CAPTURE: state_n = emit & last ? DONE : CAPTURE;
      DONE: state_n = cfg_q.continuous & ~stop_pending & ~cmd_stop ? ARMED : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      stop_pending <= 1'b0;
      cfg_q <= '0;
      out_valid <= 1'b0;
      out_visual <= 1'b0;
      out_done <= 1'b0;
      out_x <= '0;
      out_y <= '0;
      busy <= 1'b0;
      error <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      stop_pending <= done ? 1'b0 : stop_pending | (state == CAPTURE & cmd_stop);
      if (start) cfg_q <= cfg_eff;
      out_valid <= emit;
      out_visual <= emit & roi_hit;
      out_done <= done;
      out_x <= emit ? cur_x : '0;
      out_y <= emit ? cur_y : '0;
      busy <= state_n != IDLE;
      error <= set_err | (error & ~clr_err);
      frame_count <= frame_count + FCNT_W'(done);
    end
  end
endmodule

// File: tb/tb_gray_capture_sequencer.sv
// tb_gray_capture_sequencer: directed stimulus checked against a pixel-index model every cycle
module tb_gray_capture_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_start = 1'b0, cmd_stop = 1'b0, cfg_continuous = 1'b0;
  logic in_frame_start = 1'b0, in_valid = 1'b0;
  logic [11:0] cfg_width = 12'd4, cfg_height = 12'd3;
  logic [11:0] cfg_roi_x0 = 12'd1, cfg_roi_x1 = 12'd2, cfg_roi_y0 = 12'd1, cfg_roi_y1 = 12'd1;
  logic out_valid, out_visual, out_done, busy, error;
  logic [11:0] out_x, out_y;
  logic [15:0] frame_count;
  int checks = 0, passed = 0;
  int n_valid = 0, n_vis = 0, n_done = 0;
  bit m_armed = 0, m_capt = 0, m_fin = 0, m_stop_p = 0, m_err = 0, l_cont = 0;
  int m_fc = 0, m_idx = 0, lw = 1, lh = 1, lx0 = 0, lx1 = 0, ly0 = 0, ly1 = 0;
  bit e_valid = 0, e_vis = 0, e_done = 0;
  int ex = 0, ey = 0;

  always #5 clock = ~clock;

  gray_capture_sequencer dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_continuous(cfg_continuous), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_roi_x0(cfg_roi_x0), .cfg_roi_x1(cfg_roi_x1), .cfg_roi_y0(cfg_roi_y0), .cfg_roi_y1(cfg_roi_y1),
    .in_frame_start(in_frame_start), .in_valid(in_valid), .out_valid(out_valid),
    .out_visual(out_visual), .out_done(out_done), .out_x(out_x), .out_y(out_y),
    .busy(busy), .error(error), .frame_count(frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_latch();
    l_cont = cfg_continuous;
    lw = int'(cfg_width);
    lh = int'(cfg_height);
    lx0 = int'(cfg_roi_x0);
    lx1 = int'(cfg_roi_x1);
    ly0 = int'(cfg_roi_y0);
    ly1 = int'(cfg_roi_y1);
    m_idx = 0;
  endtask

  task automatic model_pixel();
    e_valid = 1;
    ex = m_idx % lw;
    ey = m_idx / lw;
    e_vis = ex >= lx0 && ex <= lx1 && ey >= ly0 && ey <= ly1;
    m_idx++;
    if (m_idx == lw * lh) begin
      m_capt = 0;
      m_fin = 1;
    end
  endtask

  always @(posedge clock) begin
    e_valid = 0;
    e_vis = 0;
    e_done = 0;
    ex = 0;
    ey = 0;
    if (reset) begin
      m_armed = 0; m_capt = 0; m_fin = 0; m_stop_p = 0; m_err = 0; m_fc = 0;
    end else if (m_fin) begin
      e_done = 1;
      m_fc = (m_fc + 1) % 65536;
      m_fin = 0;
      m_armed = l_cont && !m_stop_p && !cmd_stop;
      m_stop_p = 0;
    end else if (m_armed) begin
      if (cmd_stop) m_armed = 0;
      else if (in_valid && in_frame_start) begin
        m_armed = 0;
        m_capt = 1;
        model_latch();
        model_pixel();
      end
    end else if (m_capt) begin
      if (cmd_stop) m_stop_p = 1;
      if (in_valid) begin
        if (in_frame_start) begin
          m_err = 1;
          model_latch();
        end
        model_pixel();
      end
    end else if (cmd_start && !cmd_stop && cfg_width != '0 && cfg_height != '0) begin
      m_armed = 1;
      m_err = 0;
    end
  end

  always @(negedge clock) begin
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_visual", 32'(out_visual), 32'(e_vis));
    check("out_done", 32'(out_done), 32'(e_done));
    check("busy", 32'(busy), 32'(m_armed || m_capt || m_fin));
    check("error", 32'(error), 32'(m_err));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    if (e_valid) begin
      check("out_x", 32'(out_x), 32'(ex));
      check("out_y", 32'(out_y), 32'(ey));
    end
    n_valid += int'(out_valid);
    n_vis += int'(out_visual);
    n_done += int'(out_done);
  end

  task automatic tick(input bit st, input bit sp, input bit v, input bit f);
    @(negedge clock);
    cmd_start = st;
    cmd_stop = sp;
    in_valid = v;
    in_frame_start = f;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0);
  endtask

  task automatic frame(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(0, 0, 1, i == 0);
      idle(gap);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_tally();
    n_valid = 0;
    n_vis = 0;
    n_done = 0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sync();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_fcnt", 32'(frame_count), 32'd0);
    // single shot 4x3, ROI x 1..2, y 1..1
    clear_tally();
    tick(1, 0, 0, 0);
    frame(12, 0);
    idle(3);
    sync();
    check("t1_valid", n_valid, 12);
    check("t1_visual", n_vis, 2);
    check("t1_done", n_done, 1);
    check("t1_fcnt", 32'(frame_count), 32'd1);
    check("t1_model_fcnt", m_fc, 1);
    check("t1_busy", 32'(busy), 32'd0);
    // continuous: two frames with gaps, config change only takes effect on frame two
    cfg_continuous = 1'b1;
    clear_tally();
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 1);
    idle(3);
    cfg_roi_x0 = 12'd3;
    cfg_roi_x1 = 12'd1;
    for (int i = 0; i < 11; i++) begin
      tick(0, 0, 1, 0);
      if (i < 10) idle(3);
    end
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    frame(12, 3);
    idle(2);
    tick(0, 1, 0, 0);
    idle(2);
    sync();
    check("t2_valid", n_valid, 24);
    check("t2_visual", n_vis, 2);
    check("t2_done", n_done, 2);
    check("t2_fcnt", 32'(frame_count), 32'd3);
    check("t2_busy", 32'(busy), 32'd0);
    // stop mid-frame in continuous mode
    cfg_roi_x0 = 12'd1;
    cfg_roi_x1 = 12'd2;
    clear_tally();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) tick(0, i == 5, 1, i == 0);
    idle(3);
    frame(12, 0);
    idle(2);
    sync();
    check("t3_valid", n_valid, 12);
    check("t3_done", n_done, 1);
    check("t3_fcnt", 32'(frame_count), 32'd4);
    check("t3_busy", 32'(busy), 32'd0);
    // frame restart at pixel 7 of 12
    cfg_continuous = 1'b0;
    clear_tally();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 0, 1, i == 0);
    frame(12, 0);
    sync();
    check("t4_error", 32'(error), 32'd1);
    idle(3);
    sync();
    check("t4_valid", n_valid, 19);
    check("t4_done", n_done, 1);
    check("t4_fcnt", 32'(frame_count), 32'd5);
    tick(1, 0, 0, 0);
    sync();
    check("t4_err_clear", 32'(error), 32'd0);
    check("t4_armed_busy", 32'(busy), 32'd1);
    tick(0, 1, 0, 0);
    idle(1);
    sync();
    check("t4_stop_busy", 32'(busy), 32'd0);
    // zero width start ignored; start+stop together from ARMED
    cfg_width = 12'd0;
    tick(1, 0, 0, 0);
    idle(1);
    sync();
    check("t5_zero_width", 32'(busy), 32'd0);
    cfg_width = 12'd4;
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    idle(1);
    sync();
    check("t5_start_stop", 32'(busy), 32'd0);
    // reset at pixel 6
    tick(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, i == 0);
    tick(0, 0, 1, 0);
    reset = 1'b1;
    sync();
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_fcnt", 32'(frame_count), 32'd0);
    check("t6_x", 32'(out_x), 32'd0);
    tick(0, 0, 1, 0);
    reset = 1'b0;
    clear_tally();
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);
    idle(2);
    sync();
    check("t6_after_valid", n_valid, 0);
    check("t6_after_done", n_done, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gray_capture_sequencer.md
Name: gray_capture_sequencer

Overview:
- Frame-level controller placed in front of the camera RGB-to-gray stage.
- Arms on a software start command, aligns to the next frame start, and counts pixel coordinates.
- Gates the pixel-valid strobe, generates the region-of-interest "visual" flag, and pulses "done" after the last pixel of each captured frame.
- Supports single-shot and continuous capture; configuration is latched per frame.

Parameters:
COORD_W, 12, width of x/y coordinates and size/ROI config fields
FCNT_W, 16, width of captured-frame counter

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_start  in  1  one-cycle pulse: arm capture
cmd_stop  in  1  one-cycle pulse: stop capture
cfg_continuous  in  1  1 = re-arm automatically after each frame
cfg_width  in  COORD_W  pixels per line, must be nonzero
cfg_height  in  COORD_W  lines per frame, must be nonzero
cfg_roi_x0 / cfg_roi_x1  in  COORD_W each  ROI column bounds, inclusive
cfg_roi_y0 / cfg_roi_y1  in  COORD_W each  ROI row bounds, inclusive
in_frame_start  in  1  marks first pixel of a frame, qualified by in_valid
in_valid  in  1  sensor pixel strobe
out_valid  out  1  gated pixel strobe to the gray stage
out_visual  out  1  current out_valid pixel lies inside the ROI
out_done  out  1  one-cycle pulse after the last pixel of a captured frame
out_x / out_y  out  COORD_W each  coordinates of the current out_valid pixel
busy  out  1  state is not IDLE
error  out  1  sticky flag for frame restart mid-frame; cleared by cmd_start
frame_count  out  FCNT_W  captured frames completed; wraps at maximum value

Behaviour:
- Reset value of every output is 0; state = IDLE; counters = 0; stop_pending = 0.
- All outputs are registered, so latency from input to output is 1 cycle.
- Frame start is defined as in_frame_start & in_valid. A frame start is itself pixel (0,0).
- States:
  - IDLE: cmd_start with cfg_width != 0 and cfg_height != 0 -> ARMED; clears error. cmd_start with a zero width or height is ignored.
  - ARMED: on frame start, latch all cfg_* fields, set x=0 and y=0, emit the pixel -> CAPTURE. cmd_stop -> IDLE in the same cycle.
  - CAPTURE: each in_valid emits out_valid=1 with the current x and y.
    - x increments per pixel. At x = width-1, x resets to 0 and y increments.
    - Pixel (width-1, height-1) is the last pixel -> DONE.
  - DONE (1 cycle): out_done=1 and frame_count+1.
    - If cfg_continuous and !stop_pending -> ARMED; otherwise -> IDLE.
    - stop_pending is cleared.
- Pixels arriving while in DONE are dropped. In continuous mode, the next frame must still start with a frame-start pixel.
- out_visual = (x0 <= x <= x1) && (y0 <= y <= y1), using latched values and unsigned compares. If x0 > x1 or y0 > y1, out_visual is always 0. out_visual is 0 whenever out_valid = 0.
- cmd_stop in CAPTURE sets stop_pending. The current frame completes, then the block goes to IDLE.
- A frame start in CAPTURE before the last pixel:
  - sets error;
  - does not pulse out_done and does not increment frame_count;
  - re-latches cfg and restarts at (0,0), emitting that pixel, and stays in CAPTURE.
- in_valid = 0 cycles hold the counters; gaps of any length are allowed.
- Outside CAPTURE, and in the ARMED cycle before a frame start, out_valid = 0.
- If cmd_start and cmd_stop arrive in the same cycle, stop wins: in IDLE nothing happens; in ARMED the block goes to IDLE.
- cmd_start in ARMED, CAPTURE or DONE is ignored.
- frame_count wraps from 2^FCNT_W-1 to 0.
- Reset asserted mid-frame forces the reset values on the next edge. The interrupted frame produces no done pulse.

Decomposition:
- Shared package gray_capture_pkg: state enum (IDLE, ARMED, CAPTURE, DONE), COORD_W and FCNT_W defaults, and a latched-config struct.
- One sub-module, pixel_xy_counter: x/y counter with load-zero, enable, width/height inputs, and a last-pixel output.
- ROI compare and the FSM stay in the top level.

Test Plan:
- Single shot, width 4, height 3, ROI x 1..2 / y 1..1: start, then 12 valid pixels with a frame start on the first -> 12 out_valid, out_visual on (1,1) and (2,1) only, out_done one cycle after the 12th pixel, frame_count = 1, then IDLE.
- Continuous mode, two back-to-back 4x3 frames with 3-cycle valid gaps -> two done pulses and frame_count = 2. Pixels sent while in DONE are dropped.
- cmd_stop at pixel 5 of a continuous capture -> the frame completes, out_done pulses once, then IDLE and busy = 0.
- Frame start at pixel 7 of 12 -> error = 1, no done, counters restart at (0,0). A full frame after that gives done. A subsequent cmd_start clears error.
- cmd_start with cfg_width = 0 -> stays IDLE and busy = 0. cmd_start and cmd_stop in the same cycle from ARMED -> IDLE.
- Reset asserted at pixel 6 -> all outputs 0 on the next cycle. The remaining pixels produce no out_valid until a new cmd_start and frame start.
